// File: rtl/uart_pkg.sv
// ---- uart_pkg : shared UART constants, FSM encoding, baud divisor helper ----
// ---- rev 1.0                                                             ----
`default_nettype none

package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  localparam int ST_W = 3;
  localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [ST_W-1:0] ST_START = 3'd1;
  localparam logic [ST_W-1:0] ST_DATA  = 3'd2;
  localparam logic [ST_W-1:0] ST_STOP  = 3'd3;
  localparam logic [ST_W-1:0] ST_BREAK = 3'd4;

  function automatic int unsigned baud_div(input logic [31:0] clk_freq,
                                           input logic [31:0] baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_sync_edge.sv
// ---- uart_sync_edge : 2-flop synchroniser + delay flop, falling-edge strobe ----
// ---- rev 1.0                                                               ----
`default_nettype none

module uart_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_dly;

  // Flops reset high so an idle line never looks like a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_dly  <= 1'b1;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_dly  <= r_sync;
    end
  end

  assign o_sync = r_sync;
  assign o_fall = r_dly & ~r_sync;

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ---- uart_rx : 8N1 UART receiver, LSB first, mid-bit sampling ----
// ---- rev 1.0                                                  ----
`default_nettype none

module uart_rx
  import uart_pkg::*;
#(
  parameter logic [31:0] CLK_FREQ  = 32'd50_000_000,
  parameter logic [31:0] BAUD_RATE = 32'd115_200
) (
  input  logic                      clk_50m,
  input  logic                      reset_n,
  input  logic                      uart_rxd,
  output logic [UART_DATA_BITS-1:0] uart_rx_data,
  output logic                      uart_rx_done,
  output logic                      uart_rx_frame_err,
  output logic                      uart_rx_busy
);

  localparam int unsigned BAUD_DIV = baud_div(CLK_FREQ, BAUD_RATE);
  localparam int unsigned HALF_DIV = BAUD_DIV / 2;
  localparam int          CNT_W    = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BAUD_DIV - 1);

  logic w_rxd_s;
  logic w_start_edge;

  uart_sync_edge u_sync (
    .clk    (clk_50m),
    .rst_n  (reset_n),
    .i_async(uart_rxd),
    .o_sync (w_rxd_s),
    .o_fall (w_start_edge)
  );

  logic [ST_W-1:0]           r_state;
  logic [ST_W-1:0]           w_next;
  logic [CNT_W-1:0]          r_cnt;
  logic [2:0]                r_idx;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic [UART_DATA_BITS-1:0] r_data;
  logic                      r_done;
  logic                      r_ferr;

  logic w_half_hit;
  logic w_full_hit;
  logic w_cnt_clr;
  logic w_shift_en;
  logic w_load;
  logic w_ferr_set;
  logic w_busy;

  assign w_half_hit = (r_cnt == CNT_HALF);
  assign w_full_hit = (r_cnt == CNT_FULL);

  always_ff @(posedge clk_50m or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_start_edge) w_next = ST_START;
      ST_START: if (w_half_hit) w_next = w_rxd_s ? ST_IDLE : ST_DATA;
      ST_DATA:  if (w_full_hit && (r_idx == 3'd7)) w_next = ST_STOP;
      // Returning to IDLE at the stop-bit centre lets a zero-gap next frame be caught.
      ST_STOP:  if (w_full_hit) w_next = w_rxd_s ? ST_IDLE : ST_BREAK;
      ST_BREAK: if (w_rxd_s) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_shift_en = (r_state == ST_DATA) && w_full_hit;
    w_load     = (r_state == ST_STOP) && w_full_hit && w_rxd_s;
    w_ferr_set = (r_state == ST_STOP) && w_full_hit && !w_rxd_s;
    w_busy     = (r_state != ST_IDLE);
    w_cnt_clr  = (r_state == ST_IDLE) || (r_state == ST_BREAK) ||
                 (r_state != w_next) || w_shift_en;
  end

  always_ff @(posedge clk_50m or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= '0;
      r_idx   <= 3'd0;
      r_shift <= '0;
      r_data  <= '0;
      r_done  <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_cnt <= w_cnt_clr ? '0 : r_cnt + CNT_W'(1);
      if (r_state != ST_DATA) begin
        r_idx <= 3'd0;
      end else if (w_shift_en) begin
        r_shift[r_idx] <= w_rxd_s;
        r_idx          <= r_idx + 3'd1;
      end
      r_done <= w_load;
      r_ferr <= w_ferr_set;
      if (w_load) r_data <= r_shift;
    end
  end

  assign uart_rx_data      = r_data;
  assign uart_rx_done      = r_done;
  assign uart_rx_frame_err = r_ferr;
  assign uart_rx_busy      = w_busy;

endmodule

`default_nettype wire
